// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Sequences one ALU operation per start request. The sequencer latches the
// opcode and operands, presents them to an external combinational ALU, and
// waits a programmable number of cycles for multiply/divide. It then captures
// the 64-bit result and pulses the matching write strobe together with done.
//
// Build option:
//   ALU_SEQ_HILO_EN  defined   -> mul/div write back low word (lo_we), then
//                                 high word (hi_we, done).
//                    undefined -> mul/div write back the low word only
//                                 (rc_we, done), and hi_we is constant 0.
//
// Parameter:
//   MULDIV_WAIT  wait cycles granted to mul/div before capture (1..15)
//
// Ports:
//   clk                 rising-edge clock
//   clear               synchronous active-high reset
//   start               operation request, honoured only in IDLE
//   op[4:0]             opcode (ALU encoding)
//   a, b[31:0]          operand A (to Y) and operand B
//   alu_opcode[4:0]     opcode to ALU (nop outside EXEC/WAIT/CAPTURE)
//   alu_RY, alu_RB      latched operands to ALU
//   alu_RC[63:0]        ALU result
//   result_lo/hi[31:0]  captured result words
//   rc_we/lo_we/hi_we   write strobes
//   done/busy/halted/illegal  status
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_RY,
  output logic [31:0] alu_RB,
  input  logic [63:0] alu_RC,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        rc_we,
  output logic        lo_we,
  output logic        hi_we,
  output logic        done,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  localparam logic [4:0] OP_MUL     = 5'b01110;
  localparam logic [4:0] OP_DIV     = 5'b01111;
  localparam logic [4:0] OP_NOP     = 5'b11001;
  localparam logic [4:0] OP_HALT    = 5'b11010;
  localparam logic [4:0] OP_ILL_MIN = 5'b11011;

  // Counter is preloaded with WAIT-1 so the WAIT state lasts exactly WAIT cycles
  localparam logic [3:0] WAIT_LOAD  = 4'(MULDIV_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_Y   = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT     = 3'd3,
    S_CAPTURE  = 3'd4,
    S_WRITE_LO = 3'd5,
    S_WRITE_HI = 3'd6,
    S_HALTED   = 3'd7
  } state_t;

  function automatic logic f_is_muldiv(input logic [4:0] o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

  // nop and the reserved opcodes both finish in LOAD_Y without touching the ALU
  function automatic logic f_is_nopish(input logic [4:0] o);
    return (o == OP_NOP) || (o >= OP_ILL_MIN);
  endfunction

  function automatic logic f_is_illegal(input logic [4:0] o);
    return (o >= OP_ILL_MIN);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_op;
  logic [4:0]  w_op_nxt;
  logic [31:0] r_y;
  logic [31:0] r_b;
  logic [63:0] r_z;
  logic [3:0]  r_cnt;

  logic [4:0]  r_alu_opcode, w_alu_opcode;
  logic        r_rc_we, w_rc_we;
  logic        r_lo_we, w_lo_we;
  logic        r_hi_we, w_hi_we;
  logic        r_done, w_done;
  logic        r_busy, w_busy;
  logic        r_halted, w_halted;
  logic        r_illegal, w_illegal;

  // State register
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) w_state_nxt = S_LOAD_Y;
          else       w_state_nxt = S_IDLE;
        end
        S_LOAD_Y: begin
          if (r_op == OP_HALT)        w_state_nxt = S_HALTED;
          else if (f_is_nopish(r_op)) w_state_nxt = S_IDLE;
          else                        w_state_nxt = S_EXEC;
        end
        S_EXEC: begin
          if (f_is_muldiv(r_op)) w_state_nxt = S_WAIT;
          else                   w_state_nxt = S_CAPTURE;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) w_state_nxt = S_CAPTURE;
          else               w_state_nxt = S_WAIT;
        end
        S_CAPTURE:  w_state_nxt = S_WRITE_LO;
        S_WRITE_LO: begin
`ifdef ALU_SEQ_HILO_EN
          if (f_is_muldiv(r_op)) w_state_nxt = S_WRITE_HI;
          else                   w_state_nxt = S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
        S_WRITE_HI: w_state_nxt = S_IDLE;
        S_HALTED:   w_state_nxt = S_HALTED;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Opcode that will be held after this edge; output decode looks one cycle ahead
  always_comb begin
    if (!clear && (r_state == S_IDLE) && start) begin
      w_op_nxt = op;
    end else begin
      w_op_nxt = r_op;
    end
  end

  // Operand latch, wait counter and result capture
  always_ff @(posedge clk) begin
    if (clear) begin
      r_op  <= OP_NOP;
      r_y   <= 32'd0;
      r_b   <= 32'd0;
      r_z   <= 64'd0;
      r_cnt <= 4'd0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_op <= op;
        r_y  <= a;
        r_b  <= b;
      end
      if ((r_state == S_EXEC) && f_is_muldiv(r_op)) begin
        r_cnt <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_CAPTURE) begin
        r_z <= alu_RC;
      end
    end
  end

  // Output decode of the upcoming state; registered below so outputs are flops
  always_comb begin
    w_alu_opcode = OP_NOP;
    w_rc_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_we      = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b0;
    w_halted     = 1'b0;
    w_illegal    = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_busy = 1'b0;
      end
      S_LOAD_Y: begin
        w_busy = 1'b1;
        if (f_is_nopish(w_op_nxt)) begin
          w_done    = 1'b1;
          w_illegal = f_is_illegal(w_op_nxt);
        end else begin
          w_done    = 1'b0;
        end
      end
      S_EXEC, S_WAIT, S_CAPTURE: begin
        w_busy       = 1'b1;
        w_alu_opcode = w_op_nxt;
      end
      S_WRITE_LO: begin
        w_busy = 1'b1;
`ifdef ALU_SEQ_HILO_EN
        if (f_is_muldiv(w_op_nxt)) begin
          w_lo_we = 1'b1;
        end else begin
          w_rc_we = 1'b1;
          w_done  = 1'b1;
        end
`else
        w_rc_we = 1'b1;
        w_done  = 1'b1;
`endif
      end
      S_WRITE_HI: begin
`ifdef ALU_SEQ_HILO_EN
        w_busy  = 1'b1;
        w_hi_we = 1'b1;
        w_done  = 1'b1;
`else
        w_busy  = 1'b0;
`endif
      end
      S_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      r_alu_opcode <= OP_NOP;
      r_rc_we      <= 1'b0;
      r_lo_we      <= 1'b0;
      r_hi_we      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_alu_opcode <= w_alu_opcode;
      r_rc_we      <= w_rc_we;
      r_lo_we      <= w_lo_we;
      r_hi_we      <= w_hi_we;
      r_done       <= w_done;
      r_busy       <= w_busy;
      r_halted     <= w_halted;
      r_illegal    <= w_illegal;
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_RY     = r_y;
  assign alu_RB     = r_b;
  assign result_lo  = r_z[31:0];
  assign result_hi  = r_z[63:32];
  assign rc_we      = r_rc_we;
  assign lo_we      = r_lo_we;
  assign hi_we      = r_hi_we;
  assign done       = r_done;
  assign busy       = r_busy;
  assign halted     = r_halted;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Random and directed transactions against alu_sequencer. A behavioural ALU
// drives alu_RC from the presented opcode/operands. The expected cycle-by-cycle
// status is derived from each operation's class: write cycle, done cycle and
// opcode window relative to the start edge.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int unsigned W = 2;
  localparam logic [4:0] NOP  = 5'b11001;
  localparam logic [4:0] ADD  = 5'b00011;
  localparam logic [4:0] MUL  = 5'b01110;
  localparam logic [4:0] DIV  = 5'b01111;
  localparam logic [4:0] HALT = 5'b11010;
`ifdef ALU_SEQ_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clear, start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_RY, alu_RB;
  logic [63:0] alu_RC;
  logic [31:0] result_lo, result_hi;
  logic        rc_we, lo_we, hi_we, done, busy, halted, illegal;
  logic [6:0]  w_flags;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] model_z;

  alu_sequencer #(.MULDIV_WAIT(W)) dut (
    .clk(clk), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .alu_opcode(alu_opcode), .alu_RY(alu_RY), .alu_RB(alu_RB), .alu_RC(alu_RC),
    .result_lo(result_lo), .result_hi(result_hi),
    .rc_we(rc_we), .lo_we(lo_we), .hi_we(hi_we), .done(done),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign w_flags = {rc_we, lo_we, hi_we, done, busy, halted, illegal};

  // Behavioural ALU; nop returns a marker so a capture at the wrong time shows up
  function automatic logic [63:0] alu_model(input logic [4:0] o, input logic [31:0] y,
                                            input logic [31:0] bb);
    case (o)
      ADD:     return {32'd0, y + bb};
      MUL:     return {32'd0, y} * {32'd0, bb};
      DIV:     return (bb == 32'd0) ? {y, 32'hFFFF_FFFF} : {y % bb, y / bb};
      NOP:     return 64'hBAD0_0BAD_BAD0_0BAD;
      default: return {~y, y ^ bb ^ {27'd0, o}};
    endcase
  endfunction

  assign alu_RC = alu_model(alu_opcode, alu_RY, alu_RB);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {57'd0, w_flags}, 64'd0);
    check({tag, "_opc"}, {59'd0, alu_opcode}, {59'd0, NOP});
    check({tag, "_ry"}, {32'd0, alu_RY}, 64'd0);
    check({tag, "_rb"}, {32'd0, alu_RB}, 64'd0);
    check({tag, "_res"}, {result_hi, result_lo}, 64'd0);
  endtask

  task automatic run_txn(input logic [4:0] o, input logic [31:0] ta, input logic [31:0] tbv,
                         input int abort_at, input bit spam);
    bit          nopish, ill, hlt, md;
    bit          e_rc, e_lo, e_hi, e_done, e_ill;
    int          wr, hiw, last;
    logic [63:0] ez;
    logic [4:0]  eo;
    nopish = (o == NOP) || (o >= 5'b11011);
    ill    = (o >= 5'b11011);
    hlt    = (o == HALT);
    md     = (o == MUL) || (o == DIV);
    wr     = 4 + (md ? int'(W) : 0);
    hiw    = (HILO && md) ? wr + 1 : 0;
    last   = (nopish || hlt) ? 1 : ((hiw != 0) ? hiw : wr);
    ez     = alu_model(o, ta, tbv);

    @(negedge clk);
    start = 1'b1; op = o; a = ta; b = tbv;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
      if (k == wr && !nopish && !hlt) model_z = ez;
      e_rc   = (k == wr) && !nopish && !hlt && !(HILO && md);
      e_lo   = (k == wr) && HILO && md;
      e_hi   = (k == hiw);
      e_done = (k == last) && !hlt;
      e_ill  = (k == last) && ill;
      eo     = (!nopish && !hlt && k >= 2 && k < wr) ? o : NOP;
      check("flags", {57'd0, w_flags}, {57'd0, e_rc, e_lo, e_hi, e_done, 1'b1, 1'b0, e_ill});
      check("opcode", {59'd0, alu_opcode}, {59'd0, eo});
      check("ry", {32'd0, alu_RY}, {32'd0, ta});
      check("rb", {32'd0, alu_RB}, {32'd0, tbv});
      check("result", {result_hi, result_lo}, model_z);
      if (k == abort_at) begin
        clear = 1'b1; start = 1'($urandom);
        @(negedge clk);
        clear = 1'b0; start = 1'b0; model_z = 64'd0;
        check_reset("abort");
        return;
      end
      if (k < last || hlt) start = spam ? 1'b1 : 1'($urandom);
    end

    if (hlt) begin
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        check("halt_flags", {57'd0, w_flags}, 64'd2);
        check("halt_opc", {59'd0, alu_opcode}, {59'd0, NOP});
        check("halt_ry", {32'd0, alu_RY}, {32'd0, ta});
        start = spam ? 1'b1 : 1'($urandom);
      end
      clear = 1'b1; start = 1'b1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0; model_z = 64'd0;
      check_reset("halt_clr");
    end else begin
      @(negedge clk);
      check("idle_flags", {57'd0, w_flags}, 64'd0);
      check("idle_opc", {59'd0, alu_opcode}, {59'd0, NOP});
      check("idle_result", {result_hi, result_lo}, model_z);
    end
  endtask

  initial begin
    logic [4:0] o;
    int         sel, ab;
    clear = 1'b1; start = 1'b0; op = 5'd0; a = 32'd0; b = 32'd0; model_z = 64'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    start = 1'b1; op = ADD; a = 32'd9; b = 32'd9;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check_reset("clr_prio");

    run_txn(ADD, 32'd5, 32'd7, 0, 1'b0);
    run_txn(MUL, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    run_txn(ADD, 32'd100, 32'd23, 0, 1'b1);
    run_txn(HALT, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1);
    run_txn(DIV, 32'd100, 32'd7, 3, 1'b0);
    @(negedge clk);
    check("post_abort_flags", {57'd0, w_flags}, 64'd0);
    run_txn(5'b11100, 32'd1, 32'd2, 0, 1'b0);
    run_txn(NOP, 32'd3, 32'd4, 0, 1'b1);
    run_txn(DIV, 32'hFFFF_FFFF, 32'd3, 0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       o = ADD;
        1:       o = MUL;
        2:       o = DIV;
        3:       o = NOP;
        4:       o = 5'($urandom_range(27, 31));
        5:       o = ($urandom_range(0, 3) == 0) ? HALT : MUL;
        default: o = 5'($urandom);
      endcase
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_txn(o, $urandom, $urandom, ab, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
